apb_reg_slave: RTL and testbench



---
 rtl/apb_reg_slave_pkg.sv | 19 +
 rtl/apb_reg_slave.sv | 119 +++++++++++
 tb/tb_apb_reg_slave.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_reg_slave_pkg.sv
// rtl/apb_reg_slave_pkg.sv - shared types and constants for the APB register slave
package apb_reg_slave_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_MISALIGNED,
    ERR_RANGE,
    ERR_RO_WRITE,
    ERR_PROTOCOL
  } err_cause_e;

  localparam logic [31:0] DEFAULT_ID = 32'hA2B0_0001;

endpackage

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB3 completer with a read-only ID register and a read-write register bank
import apb_reg_slave_pkg::*;

module apb_reg_slave #(
  parameter int          AddrWidth  = 12,
  parameter int          NumRegs    = 8,
  parameter int          WaitCycles = 0,
  parameter logic [31:0] IdValue    = DEFAULT_ID
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AddrWidth-1:0]    paddr_i,
  input  logic [31:0]             pwdata_i,
  input  logic                    pwrite_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  output logic [31:0]             prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [NumRegs*32-1:0]   reg_q_o
);

  localparam logic [3:0]  WaitInit = 4'(WaitCycles);
  localparam logic [31:0] NumRegsW = 32'(NumRegs);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] regs_q [NumRegs-1:1];

  logic [AddrWidth-3:0] idx;
  logic [31:0]          idx_ext;
  logic                 misaligned;
  logic                 in_range;
  logic                 violation;
  logic                 done;
  logic                 complete;
  logic [31:0]          rd_val;
  err_cause_e           err_cause;

  assign idx        = paddr_i[AddrWidth-1:2];
  assign idx_ext    = 32'(idx);
  assign misaligned = (paddr_i[1:0] != 2'b00);
  assign in_range   = (idx_ext < NumRegsW);
  assign violation  = (state_q == IDLE) && psel_i && penable_i;
  assign done       = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign complete   = done && psel_i && penable_i;

  always_comb begin
    err_cause = ERR_NONE;
    if (violation)                     err_cause = ERR_PROTOCOL;
    else if (misaligned)               err_cause = ERR_MISALIGNED;
    else if (!in_range)                err_cause = ERR_RANGE;
    else if (pwrite_i && idx_ext == 0) err_cause = ERR_RO_WRITE;
  end

  always_comb begin
    rd_val = IdValue;
    for (int i = 1; i < NumRegs; i++) begin
      if (idx_ext == 32'(i)) rd_val = regs_q[i];
    end
  end

  // pready depends only on state/counter, except the same-cycle protocol-violation reply
  assign pready_o  = done || violation;
  assign pslverr_o = pready_o && (err_cause != ERR_NONE);
  assign prdata_o  = (done && !pwrite_i && err_cause == ERR_NONE) ? rd_val : 32'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          state_d = ACCESS;
          cnt_d   = WaitInit;
        end
      end
      ACCESS: begin
        if (!psel_i)              state_d = IDLE;
        else if (cnt_q != 4'd0)   cnt_d   = cnt_q - 4'd1;
        else if (penable_i)       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NumRegs; i++) regs_q[i] <= 32'd0;
    end else if (complete && pwrite_i && err_cause == ERR_NONE) begin
      for (int i = 1; i < NumRegs; i++) begin
        if (idx_ext == 32'(i)) regs_q[i] <= pwdata_i;
      end
    end
  end

  always_comb begin
    reg_q_o        = '0;
    reg_q_o[31:0]  = IdValue;
    for (int i = 1; i < NumRegs; i++) reg_q_o[32*i +: 32] = regs_q[i];
  end

  a_quiet_when_not_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !pready_o |-> (prdata_o == 32'd0 && !pslverr_o));

  a_protocol_is_error: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (err_cause == ERR_PROTOCOL) |-> (pready_o && pslverr_o));

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - checks two slave instances (0 and 3 wait states) against a transfer-level model
module tb_apb_reg_slave;

  localparam logic [31:0] ID = 32'hA2B0_0001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0][11:0]  paddr;
  logic [1:0][31:0]  pwdata;
  logic [1:0]        pwrite, psel, penable;
  logic [1:0][31:0]  prdata;
  logic [1:0]        pready, pslverr;
  logic [1:0][255:0] regq;

  apb_reg_slave #(.AddrWidth(12), .NumRegs(8), .WaitCycles(0), .IdValue(ID)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr[0]), .pwdata_i(pwdata[0]),
    .pwrite_i(pwrite[0]), .psel_i(psel[0]), .penable_i(penable[0]),
    .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]), .reg_q_o(regq[0]));

  apb_reg_slave #(.AddrWidth(12), .NumRegs(8), .WaitCycles(3), .IdValue(ID)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr[1]), .pwdata_i(pwdata[1]),
    .pwrite_i(pwrite[1]), .psel_i(psel[1]), .penable_i(penable[1]),
    .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]), .reg_q_o(regq[1]));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: a transfer is "in access" for a number of cycles; it answers on cycle wait+1.
  logic [31:0] mreg [2][8];
  bit          macc [2];
  int          mn   [2];

  function automatic int wc(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic bit exp_ready(input int k);
    return (macc[k] && mn[k] == wc(k) + 1) || (!macc[k] && psel[k] && penable[k]);
  endfunction

  function automatic bit exp_err(input int k);
    int a;
    a = int'(paddr[k]);
    if (!macc[k]) return 1'b1;
    return (a % 4 != 0) || (a / 4 >= 8) || (pwrite[k] && a / 4 == 0);
  endfunction

  function automatic logic [31:0] exp_rdata(input int k);
    if (exp_ready(k) && !exp_err(k) && !pwrite[k]) return mreg[k][int'(paddr[k]) / 4];
    return 32'd0;
  endfunction

  function automatic logic [255:0] exp_regq(input int k);
    logic [255:0] e;
    for (int j = 0; j < 8; j++) e[32*j +: 32] = mreg[k][j];
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        macc[k] = 1'b0;
        mn[k]   = 0;
        mreg[k][0] = ID;
        for (int j = 1; j < 8; j++) mreg[k][j] = 32'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (macc[k] && exp_ready(k) && psel[k] && penable[k] && pwrite[k] && !exp_err(k))
          mreg[k][int'(paddr[k]) / 4] = pwdata[k];
        if (!macc[k]) begin
          if (psel[k] && !penable[k]) begin
            macc[k] = 1'b1;
            mn[k]   = 1;
          end
        end else if (!psel[k] || mn[k] == wc(k) + 1) begin
          macc[k] = 1'b0;
        end else begin
          mn[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pready%0d", k), 256'(pready[k]), 256'(exp_ready(k)));
      chk($sformatf("pslverr%0d", k), 256'(pslverr[k]), 256'(exp_ready(k) && exp_err(k)));
      chk($sformatf("prdata%0d", k), 256'(prdata[k]), 256'(exp_rdata(k)));
      chk($sformatf("reg_q%0d", k), regq[k], exp_regq(k));
    end
  end

  task automatic xfer(input int k, input logic [11:0] addr, input bit wr, input logic [31:0] wd,
                      output logic [31:0] rd, output bit err, output int cyc);
    @(posedge clk); #1;
    paddr[k] = addr; pwrite[k] = wr; pwdata[k] = wd; psel[k] = 1'b1; penable[k] = 1'b0;
    cyc = 1;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    cyc++;
    #1;
    while (!pready[k] && cyc < 40) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (!pready[k]) chk("xfer_timeout", 256'(pready[k]), 256'(1));
    rd  = prdata[k];
    err = pslverr[k];
  endtask

  task automatic bus_idle(input int k);
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
  endtask

  logic [31:0] rd;
  bit          err;
  int          cyc;

  initial begin
    paddr = '0; pwdata = '0; pwrite = '0; psel = '0; penable = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_pready", 256'(pready), 256'(0));
    chk("reset_regq", regq[0], {224'd0, 32'hA2B0_0001});

    xfer(0, 12'h000, 1'b0, 32'd0, rd, err, cyc);
    chk("id_read", 256'(rd), 256'(32'hA2B0_0001));
    chk("id_err", 256'(err), 256'(0));
    chk("id_latency", 256'(cyc), 256'(2));

    xfer(0, 12'h008, 1'b1, 32'hDEAD_BEEF, rd, err, cyc);
    chk("wr8_err", 256'(err), 256'(0));
    xfer(0, 12'h008, 1'b0, 32'd0, rd, err, cyc);
    chk("rd8_b2b", 256'(rd), 256'(32'hDEAD_BEEF));
    bus_idle(0);
    #1 chk("regq_95_64", 256'(regq[0][95:64]), 256'(32'hDEAD_BEEF));

    xfer(1, 12'h004, 1'b0, 32'd0, rd, err, cyc);
    chk("w3_latency", 256'(cyc), 256'(5));
    chk("w3_rd4", 256'(rd), 256'(0));
    bus_idle(1);

    xfer(0, 12'h000, 1'b1, 32'h1111_1111, rd, err, cyc);
    chk("ro_write_err", 256'(err), 256'(1));
    xfer(0, 12'h020, 1'b1, 32'h2222_2222, rd, err, cyc);
    chk("range_write_err", 256'(err), 256'(1));
    xfer(0, 12'h006, 1'b1, 32'h3333_3333, rd, err, cyc);
    chk("misaligned_err", 256'(err), 256'(1));
    xfer(0, 12'h020, 1'b0, 32'd0, rd, err, cyc);
    chk("range_read_err", 256'(err), 256'(1));
    chk("range_read_data", 256'(rd), 256'(0));
    bus_idle(0);
    #1 chk("err_no_change", regq[0], {160'd0, 32'hDEAD_BEEF, 32'd0, 32'hA2B0_0001});

    @(posedge clk); #1;
    paddr[0] = 12'h004; pwrite[0] = 1'b1; pwdata[0] = 32'hFFFF_FFFF; psel[0] = 1'b1; penable[0] = 1'b1;
    #1;
    chk("viol_ready", 256'(pready[0]), 256'(1));
    chk("viol_err", 256'(pslverr[0]), 256'(1));
    chk("viol_data", 256'(prdata[0]), 256'(0));
    bus_idle(0);
    #1 chk("viol_no_write", 256'(regq[0][63:32]), 256'(0));

    @(posedge clk); #1;
    paddr[1] = 12'h010; pwrite[1] = 1'b1; pwdata[1] = 32'h5555_5555; psel[1] = 1'b1; penable[1] = 1'b0;
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("abort_no_write", 256'(regq[1][159:128]), 256'(0));

    @(posedge clk); #1;
    paddr[1] = 12'h00C; pwrite[1] = 1'b1; pwdata[1] = 32'h1234_5678; psel[1] = 1'b1; penable[1] = 1'b0;
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    #1 chk("rst_pready", 256'(pready[1]), 256'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("rst_discard", 256'(regq[1][127:96]), 256'(0));

    xfer(1, 12'h00C, 1'b1, 32'hCAFE_F00D, rd, err, cyc);
    chk("post_rst_err", 256'(err), 256'(0));
    bus_idle(1);
    #1 chk("post_rst_reg", 256'(regq[1][127:96]), 256'(32'hCAFE_F00D));

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
